// File: rtl/fft_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fft_frame_ctrl : streams one N-point frame into the FFT core, stores |X[k]|^2
//                  of the output bins in a RAM and tracks the peak bin.
// Revision       : 1.0
// ============================================================================
module fft_frame_ctrl #(
  parameter int DW           = 12,
  parameter int LOG2N        = 12,
  parameter int MAGW         = 24,
  parameter bit PEAK_SKIP_DC = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             mode_cont,
  input  logic             smp_valid,
  input  logic [DW-1:0]    smp_data,
  output logic             smp_ready,
  output logic             fft_sink_valid,
  output logic             fft_sink_sop,
  output logic             fft_sink_eop,
  output logic [DW-1:0]    fft_sink_real,
  output logic [DW-1:0]    fft_sink_imag,
  input  logic             fft_sink_ready,
  input  logic             fft_src_valid,
  input  logic             fft_src_sop,
  input  logic             fft_src_eop,
  input  logic [DW-1:0]    fft_src_real,
  input  logic [DW-1:0]    fft_src_imag,
  output logic             fft_src_ready,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [MAGW-1:0]  rd_mag,
  output logic             rd_valid,
  output logic [LOG2N-1:0] peak_bin,
  output logic [MAGW-1:0]  peak_mag,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);

  localparam int              N    = 2**LOG2N;
  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LOG2N-1:0]  in_cnt_q, in_cnt_d;
  logic [LOG2N-1:0]  bin_cnt_q, bin_cnt_d;
  logic              s1_vld_q, s1_vld_d;
  logic signed [DW-1:0] s1_re_q, s1_re_d;
  logic signed [DW-1:0] s1_im_q, s1_im_d;
  logic [LOG2N-1:0]  s1_bin_q, s1_bin_d;
  logic [MAGW-1:0]   run_mag_q, run_mag_d;
  logic [LOG2N-1:0]  run_bin_q, run_bin_d;
  logic [MAGW-1:0]   peak_mag_q, peak_mag_d;
  logic [LOG2N-1:0]  peak_bin_q, peak_bin_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic [MAGW-1:0]   rd_mag_q, rd_mag_d;
  logic              rd_valid_q, rd_valid_d;

  logic [MAGW-1:0]   mem [N];

  logic                  w_in_load;
  logic                  w_in_cap;
  logic                  w_take;
  logic                  w_ferr;
  logic                  w_last;
  logic                  w_wr;
  logic [LOG2N-1:0]      w_bin;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic [MAGW-1:0]       w_mag;

  assign w_in_load = (state_q == ST_LOAD);
  assign w_in_cap  = (state_q == ST_WAIT_OUT) || (state_q == ST_CAPTURE);

  assign smp_ready      = w_in_load & fft_sink_ready;
  assign fft_sink_valid = w_in_load & smp_valid;
  assign fft_sink_sop   = w_in_load & (in_cnt_q == '0);
  assign fft_sink_eop   = w_in_load & (in_cnt_q == LAST);
  assign fft_sink_real  = w_in_load ? smp_data : '0;
  assign fft_sink_imag  = '0;
  assign fft_src_ready  = w_in_cap;

  // While waiting for the core, only a sop beat opens the frame as bin 0.
  assign w_bin  = (state_q == ST_WAIT_OUT) ? '0 : bin_cnt_q;
  assign w_take = fft_src_valid & w_in_cap & ((state_q == ST_CAPTURE) | fft_src_sop);
  assign w_ferr = w_take & ((fft_src_eop & (w_bin != LAST)) | (fft_src_sop & (w_bin != '0)));
  assign w_last = w_take & fft_src_eop & (w_bin == LAST);
  assign w_wr   = s1_vld_q & ~w_ferr;

  // Squares of two's-complement values are non-negative; their sum fits MAGW unsigned.
  assign w_re_sq = s1_re_q * s1_re_q;
  assign w_im_sq = s1_im_q * s1_im_q;
  assign w_mag   = MAGW'($unsigned(w_re_sq)) + MAGW'($unsigned(w_im_sq));

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    bin_cnt_d    = bin_cnt_q;
    s1_vld_d     = 1'b0;
    s1_re_d      = s1_re_q;
    s1_im_d      = s1_im_q;
    s1_bin_d     = s1_bin_q;
    run_mag_d    = run_mag_q;
    run_bin_d    = run_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    rd_valid_d   = rd_en;
    rd_mag_d     = rd_en ? mem[rd_addr] : rd_mag_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          err_d    = 1'b0;
          in_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (smp_valid && fft_sink_ready) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST) begin
            state_d  = ST_WAIT_OUT;
            in_cnt_d = '0;
          end
        end
      end
      ST_WAIT_OUT, ST_CAPTURE: begin
        if (w_ferr) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          bin_cnt_d = '0;
        end else if (w_take) begin
          s1_vld_d  = 1'b1;
          s1_re_d   = $signed(fft_src_real);
          s1_im_d   = $signed(fft_src_imag);
          s1_bin_d  = w_bin;
          bin_cnt_d = w_bin + 1'b1;
          state_d   = w_last ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_DONE: begin
        in_cnt_d  = '0;
        bin_cnt_d = '0;
        state_d   = mode_cont ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strictly-greater compare keeps the lowest bin on ties.
    if (w_wr) begin
      if (s1_bin_q == '0) begin
        run_bin_d = '0;
        run_mag_d = PEAK_SKIP_DC ? '0 : w_mag;
      end else if (w_mag > run_mag_q) begin
        run_bin_d = s1_bin_q;
        run_mag_d = w_mag;
      end
      if (s1_bin_q == LAST) begin
        frame_done_d = 1'b1;
        peak_bin_d   = run_bin_d;
        peak_mag_d   = run_mag_d;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      bin_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_re_q      <= '0;
      s1_im_q      <= '0;
      s1_bin_q     <= '0;
      run_mag_q    <= '0;
      run_bin_q    <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      rd_mag_q     <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      bin_cnt_q    <= bin_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_re_q      <= s1_re_d;
      s1_im_q      <= s1_im_d;
      s1_bin_q     <= s1_bin_d;
      run_mag_q    <= run_mag_d;
      run_bin_q    <= run_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      rd_mag_q     <= rd_mag_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      mem[s1_bin_q] <= w_mag;
    end
  end

  assign rd_mag     = rd_mag_q;
  assign rd_valid   = rd_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fft_frame_ctrl : directed bench for fft_frame_ctrl (N=16), bench drives
//                     the FFT core output side with hand-chosen bin values.
// Revision          : 1.0
// ============================================================================
module tb_fft_frame_ctrl;

  localparam int DW    = 12;
  localparam int LOG2N = 4;
  localparam int MAGW  = 24;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic             start = 1'b0;
  logic             mode_cont = 1'b0;
  logic             smp_valid = 1'b0;
  logic [DW-1:0]    smp_data = '0;
  logic             smp_ready;
  logic             fft_sink_valid, fft_sink_sop, fft_sink_eop;
  logic [DW-1:0]    fft_sink_real, fft_sink_imag;
  logic             fft_sink_ready = 1'b0;
  logic             fft_src_valid = 1'b0;
  logic             fft_src_sop = 1'b0;
  logic             fft_src_eop = 1'b0;
  logic [DW-1:0]    fft_src_real = '0;
  logic [DW-1:0]    fft_src_imag = '0;
  logic             fft_src_ready;
  logic             rd_en = 1'b0;
  logic [LOG2N-1:0] rd_addr = '0;
  logic [MAGW-1:0]  rd_mag;
  logic             rd_valid;
  logic [LOG2N-1:0] peak_bin;
  logic [MAGW-1:0]  peak_mag;
  logic             frame_done, busy, err;

  always #5 sys_clk = ~sys_clk;

  fft_frame_ctrl #(
    .DW(DW), .LOG2N(LOG2N), .MAGW(MAGW), .PEAK_SKIP_DC(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode_cont(mode_cont),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag), .fft_sink_ready(fft_sink_ready),
    .fft_src_valid(fft_src_valid), .fft_src_sop(fft_src_sop), .fft_src_eop(fft_src_eop),
    .fft_src_real(fft_src_real), .fft_src_imag(fft_src_imag), .fft_src_ready(fft_src_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_mag(rd_mag), .rd_valid(rd_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .frame_done(frame_done),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int busy_drop = 0;
  bit mon_cont = 1'b0;
  int re_v [16];
  int im_v [16];

  always @(negedge sys_clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (mon_cont && busy !== 1'b1) busy_drop++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Source side offers sample k until accepted; checks pass-through, framing and ready path.
  task automatic load_frame(input bit toggle, output int nacc, output int ncyc,
                            output bit order_ok, output bit frame_ok);
    int k = 0;
    int cyc = 0;
    order_ok = 1'b1;
    frame_ok = 1'b1;
    while (k < 16 && cyc < 200) begin
      smp_valid      = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      fft_sink_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      smp_data       = 12'(k);
      #1;
      if (smp_ready !== fft_sink_ready || fft_sink_valid !== smp_valid) frame_ok = 1'b0;
      if (smp_valid && fft_sink_ready) begin
        if (fft_sink_real !== 12'(k) || fft_sink_imag !== 12'd0) order_ok = 1'b0;
        if (fft_sink_sop !== (k == 0) || fft_sink_eop !== (k == 15)) frame_ok = 1'b0;
        k++;
      end
      tick();
      cyc++;
    end
    smp_valid = 1'b0;
    nacc = k;
    ncyc = cyc;
  endtask

  task automatic send_frame(input int last);
    for (int b = 0; b <= last; b++) begin
      fft_src_valid = 1'b1;
      fft_src_sop   = (b == 0);
      fft_src_eop   = (b == last);
      fft_src_real  = 12'(re_v[b]);
      fft_src_imag  = 12'(im_v[b]);
      tick();
    end
    fft_src_valid = 1'b0;
    fft_src_sop   = 1'b0;
    fft_src_eop   = 1'b0;
  endtask

  task automatic rd_chk(input int a, input int exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = 4'(a);
    tick();
    rd_en = 1'b0;
    chk(tag, rd_mag, exp);
  endtask

  initial begin
    int n, cyc, base;
    bit ok_o, ok_f;

    // Reset state
    repeat (2) tick();
    chk("rst_ctrl", {busy, err, frame_done, smp_ready, fft_sink_valid, fft_sink_sop,
                     fft_sink_eop, fft_src_ready, rd_valid}, 0);
    chk("rst_peak", {peak_bin, peak_mag}, 0);
    sys_rst = 1'b1;
    tick();

    // Reset in the middle of a load, at beat 7
    do_start();
    for (int i = 0; i < 7; i++) begin
      smp_valid = 1'b1; fft_sink_ready = 1'b1; smp_data = 12'(i);
      tick();
    end
    smp_data = 12'd7;
    #1;
    chk("load_busy", busy, 1);
    sys_rst = 1'b0;
    #1;
    chk("rst_async", {busy, smp_ready, fft_sink_valid, fft_sink_sop, fft_sink_eop, frame_done, err}, 0);
    tick();
    sys_rst = 1'b1;
    smp_valid = 1'b0;
    tick();
    do_start();
    smp_valid = 1'b1; fft_sink_ready = 1'b1; smp_data = '0;
    #1;
    chk("sop_after_rst", {fft_sink_valid, fft_sink_sop}, 2'b11);

    // Full-rate load
    load_frame(1'b0, n, cyc, ok_o, ok_f);
    chk("t2_beats", n, 16);
    chk("t2_cycles", cyc, 16);
    chk("t2_data", ok_o, 1);
    chk("t2_framing", ok_f, 1);
    smp_valid = 1'b1; fft_sink_ready = 1'b1;
    #1;
    chk("t2_ready_off", {smp_ready, fft_sink_valid}, 0);
    chk("wait_src_ready", fft_src_ready, 1);
    smp_valid = 1'b0;

    // Stray beat without sop is discarded, then ramp re=k
    fft_src_valid = 1'b1; fft_src_real = 12'd99; fft_src_imag = '0;
    tick();
    fft_src_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin re_v[k] = k; im_v[k] = 0; end
    send_frame(15);
    chk("fd_c1", frame_done, 0);
    tick();
    chk("fd_c2", frame_done, 1);
    chk("t4_peak_bin", peak_bin, 15);
    chk("t4_peak_mag", peak_mag, 225);
    chk("t4_idle", busy, 0);
    tick();
    chk("fd_c3", frame_done, 0);
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    chk("rd_valid_hi", rd_valid, 1);
    for (int k = 0; k < 16; k++) rd_chk(k, k * k, $sformatf("mag%0d", k));
    tick();
    chk("rd_valid_lo", rd_valid, 0);

    // Backpressured load, then full-scale negative bin
    do_start();
    load_frame(1'b1, n, cyc, ok_o, ok_f);
    chk("t3_beats", n, 16);
    chk("t3_data", ok_o, 1);
    chk("t3_framing", ok_f, 1);
    for (int k = 0; k < 16; k++) begin re_v[k] = 0; im_v[k] = 0; end
    re_v[6] = -2048; im_v[6] = -2048;
    send_frame(15);
    repeat (2) tick();
    rd_chk(6, 8388608, "mag_fullscale");
    rd_chk(15, 0, "mag15_rewritten");
    chk("t5a_peak_bin", peak_bin, 6);
    chk("t5a_peak_mag", peak_mag, 8388608);

    // DC excluded; tie between bins 3 and 5 keeps bin 3
    do_start();
    load_frame(1'b0, n, cyc, ok_o, ok_f);
    for (int k = 0; k < 16; k++) begin re_v[k] = 0; im_v[k] = 0; end
    re_v[0] = 100; re_v[3] = 7; re_v[5] = 7;
    send_frame(15);
    repeat (2) tick();
    chk("t5b_peak_bin", peak_bin, 3);
    chk("t5b_peak_mag", peak_mag, 49);
    rd_chk(0, 10000, "mag_dc");

    // Early eop at bin 9
    do_start();
    load_frame(1'b0, n, cyc, ok_o, ok_f);
    base = done_cnt;
    for (int k = 0; k < 16; k++) begin re_v[k] = k + 1; im_v[k] = 0; end
    send_frame(9);
    chk("err_set", err, 1);
    chk("err_idle", busy, 0);
    chk("err_src_ready", fft_src_ready, 0);
    repeat (3) tick();
    chk("err_no_done", done_cnt - base, 0);
    chk("err_peak_kept", peak_bin, 3);

    // Continuous mode: three back-to-back frames
    mode_cont = 1'b1;
    base = done_cnt;
    do_start();
    chk("err_cleared", err, 0);
    mon_cont = 1'b1;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) tick();
      load_frame(1'b0, n, cyc, ok_o, ok_f);
      chk($sformatf("cont_beats%0d", f), n, 16);
      for (int k = 0; k < 16; k++) begin re_v[k] = k; im_v[k] = 0; end
      if (f == 2) mode_cont = 1'b0;
      send_frame(15);
    end
    mon_cont = 1'b0;
    repeat (2) tick();
    chk("cont_done_cnt", done_cnt - base, 3);
    chk("cont_busy_held", busy_drop, 0);
    chk("cont_idle", busy, 0);
    chk("cont_peak_bin", peak_bin, 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
